spu_issue_ctrl: RTL and testbench
=================================

Name: spu_issue_ctrl

Overview:
- In-order, single-issue controller for the Cell SPU-lite datapath.
- Accepts one fetched 32-bit instruction per cycle and decodes its opcode class (9/8/11-bit forms).
- Checks a 128-entry register scoreboard for RAW/WAW hazards and reserves the single register-file write port.
- Dispatches to the even pipe (fixed-point ALU) or odd pipe (load/store, branch), and later generates the matching writeback strobe.

Parameters:
- EVEN_LAT, 2, cycles from even-pipe issue to writeback (1..7).
- ODD_LAT, 4, cycles from odd-pipe issue to writeback (1..7).
- REGBITS, 7, register address width (128 x 128-bit registers).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  32  instruction word; opcode in [31:21].
- in_ready  out  1  controller accepts in_instr this cycle.
- br_done  in  1  pulse: PC unit has resolved the outstanding branch.
- ep_issue  out  1  even-pipe issue strobe.
- ep_cont  out  3  even-pipe ALU control.
- op_issue  out  1  odd-pipe issue strobe.
- op_cont  out  2  odd-pipe op: 00 load, 01 store, 10 branch.
- rd_ra, rd_rb  out  7  register-file read addresses.
- rd_rt  out  7  destination register, or store-data/branch-condition source.
- imm_en  out  1  immediate operand selected.
- imm  out  16  immediate, zero-extended from I10 or I16.
- wb_en  out  1  register-file write enable.
- wb_rt  out  7  write address.
- wb_pipe  out  1  writeback source: 0 even, 1 odd.
- illegal  out  1  sticky unsupported-opcode flag.

Behaviour:
- Clock and reset: all state updates on posedge clk; reset is synchronous, active-high.
- Reset values: state=RUN, scoreboard clear, reservations clear, all outputs 0. in_ready becomes 1 in the first cycle after reset.
- Field extraction:
  - RR form: rb=[20:14], ra=[13:7], rt=[6:0].
  - RI10 form: i10=[23:14].
  - RI16 form: i16=[22:7].
- Supported instructions, even pipe:
  - A: ep_cont 010; sources ra, rb; writes rt.
  - AI: ep_cont 010; source ra; imm; writes rt.
  - SF, SFI: ep_cont 110; same operand usage as A and AI respectively.
  - AND: ep_cont 000.
  - OR: ep_cont 001.
  - IL: ep_cont 010; no source; imm=i16; writes rt.
- Supported instructions, odd pipe:
  - LQX: op_cont 00; sources ra, rb; writes rt.
  - STQX: op_cont 01; sources ra, rb, rt; no write.
  - BR, BRA: op_cont 10; no source; imm=i16; no write.
  - BRNZ: op_cont 10; source rt; imm=i16; no write.
  - Anything else is illegal.
- Issue condition (all evaluated combinationally in RUN, with in_valid=1):
  - No source register busy.
  - Destination not busy (WAW).
  - Write-port slot at issue+LAT not reserved.
  - If all hold, in_ready=1 and the matching issue strobe fires in the same cycle.
  - If any fails, in_ready=0, no strobe, and the instruction must be held stable by fetch.
- Issue outputs (ep_issue/op_issue, cont, rd_*, imm, imm_en) are combinational from in_instr and valid only while the strobe is high. Otherwise they read 0.
- Scoreboard:
  - Busy bit for rt is set at the edge ending the issue cycle.
  - It is cleared at the edge ending the writeback cycle.
  - There is no bypass: a source whose writeback occurs in the current cycle still stalls for one cycle.
- Writeback reservation:
  - 8-slot shift register, each slot holding {valid, rt, pipe}.
  - Issue at cycle T writes slot LAT-1; the register shifts each cycle.
  - Slot 0 drives wb_en/wb_rt/wb_pipe, so wb_en is high exactly at T+LAT.
- State machine:
  - RUN -> BRWAIT on branch issue. In BRWAIT, in_ready=0, while writebacks continue to drain.
  - BRWAIT -> RUN on br_done. br_done outside BRWAIT is ignored.
  - RUN -> HALT on an illegal opcode with in_valid=1. The opcode is not accepted; illegal=1.
  - HALT is left only by reset. Pending writebacks still complete in HALT.
- Reset mid-operation: all pending writebacks are discarded and wb_en=0 the next cycle. No strobe is emitted in the reset cycle.
- EVEN_LAT=ODD_LAT is legal; the reservation check covers it.

Decomposition:
- Package spu_isa_pkg:
  - Opcode constants (A, AI, SF, SFI, AND, OR, IL, LQX, STQX, BR, BRA, BRNZ).
  - ep_cont and op_cont encodings.
  - State enum {RUN, BRWAIT, HALT}.
  - Field-position constants.
- Sub-module spu_scoreboard: 128 busy bits, three read-check ports, one set port, one clear port.
- Decode, reservation shift register and FSM stay in spu_issue_ctrl.

Test Plan:
- Basic even-pipe writeback: after reset, IL r5,0x1234 -> ep_issue=1, imm=0x1234, imm_en=1. At T+2: wb_en=1, wb_rt=5, wb_pipe=0.
- RAW stall: A r3,r1,r2 at T, then AI r4,r3,7 -> in_ready=0 for T+1..T+2. Issue at T+3 with rd_ra=3, imm=7.
- Write-port conflict: LQX r10 (ODD_LAT=4) at T, then A r11 at T+2 -> stalled one cycle (slot T+4 taken). A issues at T+3; wb at T+4 to r10, T+5 to r11.
- Branch: BRNZ r6 with r6 idle -> op_issue=1, op_cont=10, then in_ready=0. br_done pulse at T+5 -> in_ready=1 at T+6.
- Illegal opcode: MPY (01111000100) -> illegal=1, in_ready stays 0. A pending wb still fires. Reset clears illegal and the state returns to RUN.
- Reset mid-flight: STQX after LQX r9, with reset asserted at T+1 -> no wb_en for r9. The scoreboard is clear: A using r9 issues at the first cycle after reset.

Source files
------------

// File: rtl/spu_isa_pkg.sv
// ISA constants, decode record and instruction decoder shared by the
// SPU-lite issue controller and its scoreboard.
package spu_isa_pkg;

    localparam int REG_W   = 7;
    localparam int NREGS   = 128;
    localparam int NSLOTS  = 8;

    localparam int RB_LSB  = 14;
    localparam int RA_LSB  = 7;
    localparam int RT_LSB  = 0;
    localparam int I10_LSB = 14;
    localparam int I16_LSB = 7;

    // RR form, 11-bit opcode in [31:21]
    localparam logic [10:0] OP_A    = 11'b00011000000;
    localparam logic [10:0] OP_SF   = 11'b00001000000;
    localparam logic [10:0] OP_AND  = 11'b00011000001;
    localparam logic [10:0] OP_OR   = 11'b00001000001;
    localparam logic [10:0] OP_LQX  = 11'b00111000100;
    localparam logic [10:0] OP_STQX = 11'b00101000100;
    // RI10 form, 8-bit opcode in [31:24]
    localparam logic [7:0]  OP_AI   = 8'b00011100;
    localparam logic [7:0]  OP_SFI  = 8'b00001100;
    // RI16 form, 9-bit opcode in [31:23]
    localparam logic [8:0]  OP_IL   = 9'b010000001;
    localparam logic [8:0]  OP_BR   = 9'b001100100;
    localparam logic [8:0]  OP_BRA  = 9'b001100000;
    localparam logic [8:0]  OP_BRNZ = 9'b001000010;

    localparam logic [2:0] EP_AND = 3'b000;
    localparam logic [2:0] EP_OR  = 3'b001;
    localparam logic [2:0] EP_ADD = 3'b010;
    localparam logic [2:0] EP_SUB = 3'b110;

    localparam logic [1:0] OPC_LOAD   = 2'b00;
    localparam logic [1:0] OPC_STORE  = 2'b01;
    localparam logic [1:0] OPC_BRANCH = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BRWAIT = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rt;
        logic             pipe;
    } wb_slot_t;

    typedef struct packed {
        logic        legal;
        logic        even;
        logic        odd;
        logic        is_branch;
        logic [2:0]  ep_cont;
        logic [1:0]  op_cont;
        logic        use_ra;
        logic        use_rb;
        logic        use_rt;
        logic        wr_rt;
        logic        imm_en;
        logic [15:0] imm;
    } dec_t;

    function automatic dec_t even_op(input logic [2:0] cont, input logic use_rb);
        dec_t d;
        d         = '0;
        d.legal   = 1'b1;
        d.even    = 1'b1;
        d.ep_cont = cont;
        d.use_ra  = 1'b1;
        d.use_rb  = use_rb;
        d.wr_rt   = 1'b1;
        return d;
    endfunction

    function automatic dec_t odd_op(input logic [1:0] cont);
        dec_t d;
        d         = '0;
        d.legal   = 1'b1;
        d.odd     = 1'b1;
        d.op_cont = cont;
        return d;
    endfunction

    // RR opcodes are matched first; no RI10/RI16 opcode aliases an RR prefix.
    function automatic dec_t spu_decode(input logic [31:0] instr);
        dec_t d;
        d = '0;
        case (instr[31:21])
            OP_A:    d = even_op(EP_ADD, 1'b1);
            OP_SF:   d = even_op(EP_SUB, 1'b1);
            OP_AND:  d = even_op(EP_AND, 1'b1);
            OP_OR:   d = even_op(EP_OR, 1'b1);
            OP_LQX: begin
                d        = odd_op(OPC_LOAD);
                d.use_ra = 1'b1;
                d.use_rb = 1'b1;
                d.wr_rt  = 1'b1;
            end
            OP_STQX: begin
                d        = odd_op(OPC_STORE);
                d.use_ra = 1'b1;
                d.use_rb = 1'b1;
                d.use_rt = 1'b1;
            end
            default: begin
                case (instr[31:24])
                    OP_AI: begin
                        d        = even_op(EP_ADD, 1'b0);
                        d.imm_en = 1'b1;
                        d.imm    = {6'd0, instr[I10_LSB +: 10]};
                    end
                    OP_SFI: begin
                        d        = even_op(EP_SUB, 1'b0);
                        d.imm_en = 1'b1;
                        d.imm    = {6'd0, instr[I10_LSB +: 10]};
                    end
                    default: begin
                        case (instr[31:23])
                            OP_IL: begin
                                d        = even_op(EP_ADD, 1'b0);
                                d.use_ra = 1'b0;
                                d.imm_en = 1'b1;
                                d.imm    = instr[I16_LSB +: 16];
                            end
                            OP_BR, OP_BRA, OP_BRNZ: begin
                                d           = odd_op(OPC_BRANCH);
                                d.is_branch = 1'b1;
                                d.use_rt    = (instr[31:23] == OP_BRNZ);
                                d.imm_en    = 1'b1;
                                d.imm       = instr[I16_LSB +: 16];
                            end
                            default: d = '0;
                        endcase
                    end
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/spu_scoreboard.sv
// Register busy scoreboard: one busy bit per architectural register, three
// combinational check ports, one set port (issue) and one clear port (writeback).
module spu_scoreboard
    import spu_isa_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] chk_a,
    input  logic [REG_W-1:0] chk_b,
    input  logic [REG_W-1:0] chk_c,
    output logic             busy_a,
    output logic             busy_b,
    output logic             busy_c,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_addr
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_n;

    assign busy_a = busy_r[chk_a];
    assign busy_b = busy_r[chk_b];
    assign busy_c = busy_r[chk_c];

    // Next busy vector; a same-cycle set wins over a clear of the same register.
    always_comb begin
        busy_n = busy_r;
        if (clr_en) begin
            busy_n[clr_addr] = 1'b0;
        end else begin
            busy_n = busy_n;
        end
        if (set_en) begin
            busy_n[set_addr] = 1'b1;
        end else begin
            busy_n = busy_n;
        end
    end

    // Busy-bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_n;
        end
    end

endmodule

// File: rtl/spu_issue_ctrl.sv
// In-order single-issue controller: decode, scoreboard hazard check,
// write-port reservation shift register and RUN/BRWAIT/HALT sequencing.
module spu_issue_ctrl
    import spu_isa_pkg::*;
#(
    parameter int EVEN_LAT = 2,
    parameter int ODD_LAT  = 4,
    parameter int REGBITS  = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        in_instr,
    output logic               in_ready,
    input  logic               br_done,
    output logic               ep_issue,
    output logic [2:0]         ep_cont,
    output logic               op_issue,
    output logic [1:0]         op_cont,
    output logic [REGBITS-1:0] rd_ra,
    output logic [REGBITS-1:0] rd_rb,
    output logic [REGBITS-1:0] rd_rt,
    output logic               imm_en,
    output logic [15:0]        imm,
    output logic               wb_en,
    output logic [REGBITS-1:0] wb_rt,
    output logic               wb_pipe,
    output logic               illegal
);

    state_t                    state_r;
    state_t                    state_n;
    logic                      illegal_r;
    logic                      illegal_n;
    wb_slot_t [NSLOTS-1:0]     res_r;
    wb_slot_t [NSLOTS-1:0]     res_n;

    dec_t                      dec_s;
    logic [REGBITS-1:0]        ra_s;
    logic [REGBITS-1:0]        rb_s;
    logic [REGBITS-1:0]        rt_s;
    logic                      busy_a_s;
    logic                      busy_b_s;
    logic                      busy_t_s;
    logic                      hazard_s;
    logic                      port_busy_s;
    logic                      run_s;
    logic                      fire_s;
    logic                      bad_op_s;

    assign dec_s = spu_decode(in_instr);
    assign ra_s  = in_instr[RA_LSB +: REGBITS];
    assign rb_s  = in_instr[RB_LSB +: REGBITS];
    assign rt_s  = in_instr[RT_LSB +: REGBITS];

    spu_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .chk_a    (ra_s),
        .chk_b    (rb_s),
        .chk_c    (rt_s),
        .busy_a   (busy_a_s),
        .busy_b   (busy_b_s),
        .busy_c   (busy_t_s),
        .set_en   (fire_s & dec_s.wr_rt),
        .set_addr (rt_s),
        .clr_en   (res_r[0].valid),
        .clr_addr (res_r[0].rt)
    );

    // rt is checked both as a source (store/branch) and for WAW on writers.
    assign hazard_s = (dec_s.use_ra & busy_a_s) | (dec_s.use_rb & busy_b_s)
                    | ((dec_s.use_rt | dec_s.wr_rt) & busy_t_s);
    // Slot LAT holds whatever will sit in slot LAT-1 once this cycle's shift happens.
    assign port_busy_s = dec_s.wr_rt & (dec_s.odd ? res_r[ODD_LAT].valid
                                                  : res_r[EVEN_LAT].valid);
    assign run_s    = (state_r == ST_RUN) & ~reset;
    assign fire_s   = run_s & in_valid & dec_s.legal & ~hazard_s & ~port_busy_s;
    assign bad_op_s = run_s & in_valid & ~dec_s.legal;
    assign in_ready = run_s & (~in_valid | (dec_s.legal & ~hazard_s & ~port_busy_s));

    assign wb_en   = res_r[0].valid;
    assign wb_rt   = res_r[0].rt;
    assign wb_pipe = res_r[0].pipe;
    assign illegal = illegal_r;

    // Issue-side outputs, forced to zero whenever no strobe fires.
    always_comb begin
        ep_issue = 1'b0;
        op_issue = 1'b0;
        ep_cont  = 3'd0;
        op_cont  = 2'd0;
        rd_ra    = '0;
        rd_rb    = '0;
        rd_rt    = '0;
        imm_en   = 1'b0;
        imm      = 16'd0;
        if (fire_s) begin
            ep_issue = dec_s.even;
            op_issue = dec_s.odd;
            ep_cont  = dec_s.ep_cont;
            op_cont  = dec_s.op_cont;
            rd_ra    = dec_s.use_ra ? ra_s : '0;
            rd_rb    = dec_s.use_rb ? rb_s : '0;
            rd_rt    = (dec_s.use_rt | dec_s.wr_rt) ? rt_s : '0;
            imm_en   = dec_s.imm_en;
            imm      = dec_s.imm;
        end else begin
            ep_issue = 1'b0;
        end
    end

    // Reservation shift plus insertion of the newly issued writer.
    always_comb begin
        res_n = '0;
        for (int i = 0; i < NSLOTS - 1; i++) begin
            res_n[i] = res_r[i+1];
        end
        if (fire_s && dec_s.wr_rt) begin
            if (dec_s.odd) begin
                res_n[ODD_LAT-1] = {1'b1, rt_s, 1'b1};
            end else begin
                res_n[EVEN_LAT-1] = {1'b1, rt_s, 1'b0};
            end
        end else begin
            res_n[NSLOTS-1] = '0;
        end
    end

    // Next-state logic; br_done only matters while waiting on a branch.
    always_comb begin
        state_n   = state_r;
        illegal_n = illegal_r | bad_op_s;
        case (state_r)
            ST_RUN: begin
                if (bad_op_s) begin
                    state_n = ST_HALT;
                end else if (fire_s && dec_s.is_branch) begin
                    state_n = ST_BRWAIT;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_BRWAIT: begin
                if (br_done) begin
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_BRWAIT;
                end
            end
            ST_HALT: state_n = ST_HALT;
            default: state_n = ST_RUN;
        endcase
    end

    // Control state, sticky illegal flag and reservation slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_RUN;
            illegal_r <= 1'b0;
            res_r     <= '0;
        end else begin
            state_r   <= state_n;
            illegal_r <= illegal_n;
            res_r     <= res_n;
        end
    end

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Directed bench for spu_issue_ctrl with default latencies (even 2, odd 4).
module tb_spu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        br_done;
    logic        ep_issue;
    logic [2:0]  ep_cont;
    logic        op_issue;
    logic [1:0]  op_cont;
    logic [6:0]  rd_ra;
    logic [6:0]  rd_rb;
    logic [6:0]  rd_rt;
    logic        imm_en;
    logic [15:0] imm;
    logic        wb_en;
    logic [6:0]  wb_rt;
    logic        wb_pipe;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    spu_issue_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .br_done  (br_done),
        .ep_issue (ep_issue),
        .ep_cont  (ep_cont),
        .op_issue (op_issue),
        .op_cont  (op_cont),
        .rd_ra    (rd_ra),
        .rd_rb    (rd_rb),
        .rd_rt    (rd_rt),
        .imm_en   (imm_en),
        .imm      (imm),
        .wb_en    (wb_en),
        .wb_rt    (wb_rt),
        .wb_pipe  (wb_pipe),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rr(input logic [10:0] op, input logic [6:0] rb,
                                       input logic [6:0] ra, input logic [6:0] rt);
        return {op, rb, ra, rt};
    endfunction

    function automatic logic [31:0] ri10(input logic [7:0] op, input logic [9:0] i10,
                                         input logic [6:0] ra, input logic [6:0] rt);
        return {op, i10, ra, rt};
    endfunction

    function automatic logic [31:0] ri16(input logic [8:0] op, input logic [15:0] i16,
                                         input logic [6:0] rt);
        return {op, i16, rt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'd0;
        br_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        settle();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ep_issue", ep_issue, 0);
        chk("rst_op_issue", op_issue, 0);

        // IL r5,0x1234 : writeback two cycles later
        next_cycle(); in_valid = 1'b1; in_instr = ri16(9'h081, 16'h1234, 7'd5); settle();
        chk("il_ep_issue", ep_issue, 1);
        chk("il_imm", imm, 16'h1234);
        chk("il_imm_en", imm_en, 1);
        chk("il_ep_cont", ep_cont, 3'b010);
        chk("il_rd_rt", rd_rt, 5);
        chk("il_op_issue", op_issue, 0);
        next_cycle(); in_valid = 1'b0; settle();
        chk("il_wb_early", wb_en, 0);
        next_cycle(); settle();
        chk("il_wb_en", wb_en, 1);
        chk("il_wb_rt", wb_rt, 5);
        chk("il_wb_pipe", wb_pipe, 0);
        next_cycle(); settle();
        chk("il_wb_done", wb_en, 0);

        // A r3,r1,r2 then AI r4,r3,7 : RAW stall two cycles
        next_cycle(); in_valid = 1'b1; in_instr = rr(11'h0C0, 7'd2, 7'd1, 7'd3); settle();
        chk("a_ep_issue", ep_issue, 1);
        chk("a_rd_ra", rd_ra, 1);
        chk("a_rd_rb", rd_rb, 2);
        chk("a_rd_rt", rd_rt, 3);
        chk("a_imm_en", imm_en, 0);
        next_cycle(); in_instr = ri10(8'h1C, 10'd7, 7'd3, 7'd4); settle();
        chk("raw_ready_t1", in_ready, 0);
        chk("raw_issue_t1", ep_issue, 0);
        next_cycle(); settle();
        chk("raw_ready_t2", in_ready, 0);
        chk("raw_wb_en_t2", wb_en, 1);
        chk("raw_wb_rt_t2", wb_rt, 3);
        next_cycle(); settle();
        chk("raw_ready_t3", in_ready, 1);
        chk("ai_ep_issue", ep_issue, 1);
        chk("ai_rd_ra", rd_ra, 3);
        chk("ai_imm", imm, 7);
        chk("ai_imm_en", imm_en, 1);
        chk("ai_rd_rb", rd_rb, 0);

        // SF / AND / OR back to back
        next_cycle(); in_instr = rr(11'h040, 7'd22, 7'd21, 7'd20); settle();
        chk("sf_issue", ep_issue, 1);
        chk("sf_cont", ep_cont, 3'b110);
        next_cycle(); in_instr = rr(11'h0C1, 7'd25, 7'd24, 7'd23); settle();
        chk("and_issue", ep_issue, 1);
        chk("and_cont", ep_cont, 3'b000);
        next_cycle(); in_instr = rr(11'h041, 7'd28, 7'd27, 7'd26); settle();
        chk("or_issue", ep_issue, 1);
        chk("or_cont", ep_cont, 3'b001);
        next_cycle(); in_valid = 1'b0;
        repeat (3) next_cycle();

        // LQX r10 then A r11 two cycles later : write-port conflict
        in_valid = 1'b1; in_instr = rr(11'h1C4, 7'd1, 7'd2, 7'd10); settle();
        chk("lqx_op_issue", op_issue, 1);
        chk("lqx_op_cont", op_cont, 2'b00);
        chk("lqx_ep_issue", ep_issue, 0);
        next_cycle(); in_valid = 1'b0; settle();
        next_cycle(); in_valid = 1'b1; in_instr = rr(11'h0C0, 7'd1, 7'd2, 7'd11); settle();
        chk("port_stall", in_ready, 0);
        next_cycle(); settle();
        chk("port_ready", in_ready, 1);
        chk("port_issue", ep_issue, 1);
        next_cycle(); in_valid = 1'b0; settle();
        chk("port_wb_en_10", wb_en, 1);
        chk("port_wb_rt_10", wb_rt, 10);
        chk("port_wb_pipe_10", wb_pipe, 1);
        next_cycle(); settle();
        chk("port_wb_en_11", wb_en, 1);
        chk("port_wb_rt_11", wb_rt, 11);
        chk("port_wb_pipe_11", wb_pipe, 0);

        // BRNZ r6 with a stray br_done in RUN, then wait for resolution
        next_cycle(); br_done = 1'b1; in_valid = 1'b1;
        in_instr = ri16(9'h042, 16'h0040, 7'd6); settle();
        chk("brnz_op_issue", op_issue, 1);
        chk("brnz_op_cont", op_cont, 2'b10);
        chk("brnz_rd_rt", rd_rt, 6);
        chk("brnz_imm", imm, 16'h0040);
        chk("brnz_imm_en", imm_en, 1);
        next_cycle(); br_done = 1'b0; in_instr = ri16(9'h081, 16'h00AA, 7'd7); settle();
        chk("br_wait_t1", in_ready, 0);
        chk("br_wait_issue", ep_issue, 0);
        next_cycle(); next_cycle(); next_cycle(); settle();
        chk("br_wait_t4", in_ready, 0);
        next_cycle(); br_done = 1'b1; settle();
        chk("br_wait_t5", in_ready, 0);
        next_cycle(); br_done = 1'b0; settle();
        chk("br_resume_ready", in_ready, 1);
        chk("br_resume_issue", ep_issue, 1);
        chk("br_resume_imm", imm, 16'h00AA);
        next_cycle(); in_valid = 1'b0;
        repeat (2) next_cycle();

        // A r12 then MPY : halt while the pending writeback still drains
        in_valid = 1'b1; in_instr = rr(11'h0C0, 7'd1, 7'd2, 7'd12); settle();
        chk("pre_ill_issue", ep_issue, 1);
        next_cycle(); in_instr = rr(11'h3C4, 7'd1, 7'd2, 7'd13); settle();
        chk("ill_ready", in_ready, 0);
        chk("ill_flag_early", illegal, 0);
        chk("ill_op_issue", op_issue, 0);
        chk("ill_ep_issue", ep_issue, 0);
        next_cycle(); settle();
        chk("ill_flag", illegal, 1);
        chk("ill_halt_ready", in_ready, 0);
        chk("ill_wb_en", wb_en, 1);
        chk("ill_wb_rt", wb_rt, 12);
        next_cycle(); in_instr = ri16(9'h081, 16'h0001, 7'd7); settle();
        chk("halt_ready", in_ready, 0);
        next_cycle(); reset = 1'b1; in_valid = 1'b0; settle();
        chk("halt_rst_ready", in_ready, 0);
        next_cycle(); reset = 1'b0; settle();
        chk("halt_cleared", illegal, 0);
        chk("halt_run_ready", in_ready, 1);

        // LQX r9, reset during the following STQX
        next_cycle(); in_valid = 1'b1; in_instr = rr(11'h1C4, 7'd1, 7'd2, 7'd9); settle();
        chk("mid_lqx_issue", op_issue, 1);
        next_cycle(); reset = 1'b1; in_instr = rr(11'h144, 7'd3, 7'd4, 7'd5); settle();
        chk("mid_rst_strobe", op_issue, 0);
        chk("mid_rst_ready", in_ready, 0);
        next_cycle(); reset = 1'b0; in_instr = rr(11'h0C0, 7'd1, 7'd9, 7'd13); settle();
        chk("mid_a_ready", in_ready, 1);
        chk("mid_a_issue", ep_issue, 1);
        chk("mid_a_rd_ra", rd_ra, 9);
        chk("mid_wb_clear", wb_en, 0);
        next_cycle(); in_instr = rr(11'h144, 7'd3, 7'd4, 7'd5); settle();
        chk("stqx_issue", op_issue, 1);
        chk("stqx_cont", op_cont, 2'b01);
        chk("stqx_rd_rt", rd_rt, 5);
        chk("stqx_rd_ra", rd_ra, 4);
        chk("stqx_rd_rb", rd_rb, 3);
        chk("mid_wb_t3", wb_en, 0);
        next_cycle(); in_valid = 1'b0; settle();
        chk("mid_wb_en_t4", wb_en, 1);
        chk("mid_wb_rt_t4", wb_rt, 13);
        next_cycle(); settle();
        chk("mid_wb_t5", wb_en, 0);
        next_cycle(); next_cycle(); settle();
        chk("stqx_no_wb", wb_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
